// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the single-clock MIPS core.
//   DEFAULT_RESET_PC : default first fetch address after reset
//   OP_BEQ / OP_J    : opcode field values used by decode
//   fetch_state_t    : fetch sequencer states (BOOT / RUN / REDIR)
//   fetch_entry_t    : one fetch buffer entry, {instruction word, byte address}
package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam int FETCH_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_REDIR = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry synchronous FIFO holding {word, pc} pairs between the
// instruction memory and decode.
//   clk, rst   : clock and synchronous active-high reset
//   push       : write push_data this cycle
//   push_data  : entry to write
//   pop        : drop the head entry this cycle
//   flush      : discard all entries (takes priority over push and pop)
//   count      : number of valid entries, 0..2
//   head       : oldest entry; stale contents when count is 0
module fetch_buf
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t entries [FETCH_BUF_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;

    // Storage and pointers. Reset clears the storage as well so that the
    // head reads as all zeros straight out of reset; a flush only rewinds
    // the pointers because the stale words are hidden by count == 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
                entries[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = entries[rd_ptr];

    // The producer's issue rule guarantees room for every returning word;
    // a push into a full buffer without a matching pop means that rule broke.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            assert (!(push && !pop && (count == 2'd2)));
            assert (!(pop && (count == 2'd0)));
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit. Owns the PC, issues reads to the
// synchronous instruction memory (1-cycle latency) and hands one word per
// valid/ready handshake to decode. Taken branches and jumps from decode
// redirect the PC and flush every wrong-path word.
//   RESET_PC    : first fetch address after reset (word aligned)
//   clk, rst    : clock and synchronous active-high reset
//   imem_en     : read strobe; imem_addr is the word-aligned byte address
//   imem_rdata  : read data, valid the cycle after imem_en
//   instr, instr_pc, instr_valid, instr_ready : decode handshake
//   pcsrc, pcj  : taken branch / jump from decode (jump wins)
//   redir_pc4   : PC+4 of the redirecting instruction
//   br_imm      : branch offset in words, sign-extended
//   j_target    : 26-bit jump target field
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        pcsrc,
    input  logic        pcj,
    input  logic [31:0] redir_pc4,
    input  logic [15:0] br_imm,
    input  logic [25:0] j_target
);

    fetch_state_t state;
    fetch_state_t state_next;

    logic [31:0]  pc;
    logic [31:0]  inflight_pc;
    logic         inflight;
    logic         redirect;
    logic         issue;
    logic         pop;
    logic [1:0]   count;
    logic [2:0]   occupancy;
    logic [31:0]  redir_base;
    logic [31:0]  branch_target;
    logic [31:0]  jump_target;
    logic [31:0]  redir_target;
    fetch_entry_t push_data;
    fetch_entry_t head;

    // Redirect target. The low two bits of redir_pc4 carry no meaning for a
    // word-aligned PC, so they are cleared before either target is formed.
    assign redir_base    = redir_pc4 & 32'hFFFF_FFFC;
    assign branch_target = redir_base + {{14{br_imm[15]}}, br_imm, 2'b00};
    assign jump_target   = {redir_base[31:28], j_target, 2'b00};
    assign redir_target  = pcj ? jump_target : branch_target;

    assign pop       = instr_valid & instr_ready;
    assign occupancy = {1'b0, count} + {2'b00, inflight};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH_BOOT;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the two per-cycle decisions: redirect and issue.
    // A read is issued only if its word is guaranteed a buffer slot when it
    // returns next cycle, counting the word already in flight and any pop
    // happening now. Nothing is fetched while a redirect is being taken.
    always_comb begin
        state_next = state;
        redirect   = 1'b0;
        issue      = 1'b0;
        case (state)
            FETCH_BOOT: begin
                state_next = FETCH_RUN;
            end
            FETCH_RUN, FETCH_REDIR: begin
                if (!rst && (pcsrc || pcj)) begin
                    redirect   = 1'b1;
                    state_next = FETCH_REDIR;
                end else begin
                    state_next = FETCH_RUN;
                    issue      = !rst && (occupancy < (3'd2 + {2'b00, pop}));
                end
            end
            default: begin
                state_next = FETCH_BOOT;
            end
        endcase
    end

    assign imem_en   = issue;
    assign imem_addr = issue ? {pc[31:2], 2'b00} : 32'h0000_0000;

    // PC and in-flight tracking. inflight_pc remembers the address of the
    // outstanding read so it can be paired with the data that comes back.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC & 32'hFFFF_FFFC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0000_0000;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
            end
            if (redirect) begin
                pc <= redir_target;
            end else if (issue) begin
                pc <= pc + 32'd4;
            end
        end
    end

    // Returning data is pushed every cycle a read is outstanding. A redirect
    // flushes the buffer in the same cycle, which also throws away the word
    // returning right then, so the wrong-path read is dropped without a
    // separate marker; since no read is issued on a redirect cycle, nothing
    // stale can arrive afterwards.
    assign push_data.word = imem_rdata;
    assign push_data.pc   = inflight_pc;

    fetch_buf u_fetch_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head)
    );

    assign instr       = head.word;
    assign instr_pc    = head.pc;
    assign instr_valid = (count != 2'd0);

endmodule
